// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory bus between the fetch unit and the instruction memory.
//   imemRequestValid    fetch -> mem  read request valid
//   imemRequestAddress  fetch -> mem  word-aligned read address
//   imemRequestReady    mem -> fetch  request accepted this cycle
//   imemResponseValid   mem -> fetch  instruction data returned (in order)
//   imemResponseData    mem -> fetch  returned instruction word
// Modports: master = fetch unit side, slave = memory side.
// -----------------------------------------------------------------------------
interface fetch_unit_if;
  logic        imemRequestValid;
  logic [31:0] imemRequestAddress;
  logic        imemRequestReady;
  logic        imemResponseValid;
  logic [31:0] imemResponseData;

  modport master (
    output imemRequestValid,
    output imemRequestAddress,
    input  imemRequestReady,
    input  imemResponseValid,
    input  imemResponseData
  );

  modport slave (
    input  imemRequestValid,
    input  imemRequestAddress,
    output imemRequestReady,
    output imemResponseValid,
    output imemResponseData
  );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch front end: issues word-aligned reads to instruction memory,
// queues the in-order responses and presents them to decode. A redirect drops
// everything queued and discards responses still in flight (FLUSH state).
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-high reset
//   stall            decode cannot accept; head of queue is held
//   redirectValid    taken branch / jump from a later stage
//   redirectTarget   new fetch address (bits [1:0] ignored)
//   imem             instruction-memory bus (fetch_unit_if.master)
//   fetchValid       fetchInstruction / fetchPc are valid
//   fetchInstruction instruction presented to decode (0 when not valid)
//   fetchPc          address of fetchInstruction (0 when not valid)
//
// Parameters
//   RESET_PC     first fetch address after reset
//   QUEUE_DEPTH  queue entries and maximum in-flight requests (power of 2, >= 2)
//
// Configuration macro
//   FETCH_UNIT_BYPASS_EN  when defined, a response arriving into an empty queue
//                         with no stall and no redirect is forwarded to the
//                         fetch outputs in the same cycle instead of queued.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirectValid,
  input  logic [31:0]  redirectTarget,
  fetch_unit_if.master imem,
  output logic         fetchValid,
  output logic [31:0]  fetchInstruction,
  output logic [31:0]  fetchPc
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      fetch_addr_q, fetch_addr_d;
  logic [31:0]      resp_addr_q, resp_addr_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [31:0]      q_pc_q    [QUEUE_DEPTH];
  logic [31:0]      q_instr_q [QUEUE_DEPTH];

  logic [31:0]      target_s;
  logic [CNT_W:0]   occupancy_s;
  logic             req_valid_s;
  logic             req_accept_s;
  logic             resp_take_s;
  logic             bypass_s;
  logic             push_s;
  logic             pop_s;

  // Handshake decode: request gating, response acceptance, queue push/pop.
  always_comb begin
    target_s     = {redirectTarget[31:2], 2'b00};
    occupancy_s  = {1'b0, outstanding_q} + {1'b0, count_q};
    // In-flight plus queued entries never exceed the depth, so a response
    // always finds room even when nothing pops.
    req_valid_s  = (state_q == FETCH) && !redirectValid && (occupancy_s < DEPTH_W);
    req_accept_s = req_valid_s && imem.imemRequestReady;
    // Responses with nothing outstanding belong to no request.
    resp_take_s  = imem.imemResponseValid && (outstanding_q != CNT_ZERO);
`ifdef FETCH_UNIT_BYPASS_EN
    bypass_s     = resp_take_s && (state_q == FETCH) && (count_q == CNT_ZERO)
                   && !stall && !redirectValid;
`else
    bypass_s     = 1'b0;
`endif
    push_s       = resp_take_s && (state_q == FETCH) && !redirectValid && !bypass_s;
    pop_s        = (count_q != CNT_ZERO) && !stall && !redirectValid;
  end

  // Next-state logic for the FSM, address counters and queue pointers.
  always_comb begin
    state_d       = state_q;
    outstanding_d = outstanding_q + CNT_W'(req_accept_s) - CNT_W'(resp_take_s);
    if (req_accept_s) begin
      fetch_addr_d = fetch_addr_q + 32'd4;
    end else begin
      fetch_addr_d = fetch_addr_q;
    end
    // Discarded (FLUSH) responses do not advance the response address.
    if (resp_take_s && (state_q == FETCH) && !redirectValid) begin
      resp_addr_d = resp_addr_q + 32'd4;
    end else begin
      resp_addr_d = resp_addr_q;
    end
    if (redirectValid) begin
      fetch_addr_d = target_s;
      resp_addr_d  = target_s;
      head_d       = PTR_ZERO;
      tail_d       = PTR_ZERO;
      count_d      = CNT_ZERO;
    end else begin
      head_d       = head_q + PTR_W'(pop_s);
      tail_d       = tail_q + PTR_W'(push_s);
      count_d      = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
    case (state_q)
      START: state_d = FETCH;
      FETCH: begin
        if (redirectValid && (outstanding_d != CNT_ZERO)) begin
          state_d = FLUSH;
        end else begin
          state_d = FETCH;
        end
      end
      FLUSH: begin
        if (outstanding_d == CNT_ZERO) begin
          state_d = FETCH;
        end else begin
          state_d = FLUSH;
        end
      end
      default: state_d = START;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= START;
      fetch_addr_q  <= RESET_PC;
      resp_addr_q   <= RESET_PC;
      outstanding_q <= CNT_ZERO;
      count_q       <= CNT_ZERO;
      head_q        <= PTR_ZERO;
      tail_q        <= PTR_ZERO;
    end else begin
      state_q       <= state_d;
      fetch_addr_q  <= fetch_addr_d;
      resp_addr_q   <= resp_addr_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  // Queue storage: written at the tail on each push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_pc_q[i]    <= 32'h0000_0000;
        q_instr_q[i] <= 32'h0000_0000;
      end
    end else if (push_s) begin
      q_pc_q[tail_q]    <= resp_addr_q;
      q_instr_q[tail_q] <= imem.imemResponseData;
    end else begin
      q_pc_q[tail_q]    <= q_pc_q[tail_q];
      q_instr_q[tail_q] <= q_instr_q[tail_q];
    end
  end

  // Memory request outputs.
  always_comb begin
    imem.imemRequestValid   = req_valid_s;
    imem.imemRequestAddress = fetch_addr_q;
  end

  // Fetch outputs: queue head, forced to zero when nothing is valid.
  always_comb begin
    fetchValid       = 1'b0;
    fetchInstruction = 32'h0000_0000;
    fetchPc          = 32'h0000_0000;
    if (count_q != CNT_ZERO) begin
      fetchValid       = 1'b1;
      fetchInstruction = q_instr_q[head_q];
      fetchPc          = q_pc_q[head_q];
    end
`ifdef FETCH_UNIT_BYPASS_EN
    else if (bypass_s) begin
      fetchValid       = 1'b1;
      fetchInstruction = imem.imemResponseData;
      fetchPc          = resp_addr_q;
    end
`endif
    else begin
      fetchValid       = 1'b0;
      fetchInstruction = 32'h0000_0000;
      fetchPc          = 32'h0000_0000;
    end
  end

endmodule
